sram_rr_arbiter: RTL
====================

Name: sram_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-port synchronous RAM (s_ram) between two requesters, A and B.
- Accepts one read or write transaction at a time.
- Drives the RAM address, data and write-enable lines.
- Waits out the RAM read latency, then returns read data with a one-cycle ack pulse.
- Sits between the requester logic and the s_ram instance, on the same clk/rst.

Parameters:
- DW, 8: data width of RAM and requesters.
- AW, 4: address width.
- RD_LAT, 1: RAM read latency in clk cycles (1..4).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_a  in  1  requester A transaction request; held high until ack_a.
- we_a  in  1  A: 1 = write, 0 = read; stable while req_a is high.
- addr_a  in  AW  A address; stable while req_a is high.
- wdata_a  in  DW  A write data; stable while req_a is high.
- ack_a  out  1  one-cycle completion pulse to A.
- req_b, we_b, addr_b, wdata_b, ack_b  as for A, for requester B.
- rdata  out  DW  read data; valid in the ack cycle of a read.
- ram_en  out  1  RAM enable/write strobe: 1 = write, 0 = read.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data, RD_LAT cycles after address.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - ack_a = ack_b = 0, ram_en = 0, ram_addr = 0, ram_din = 0, rdata = 0, busy = 0.
  - last_gnt = B, so A wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner (round-robin tie-break: the requester that was not last_gnt wins).
  - Latch the winner's we/addr/wdata and update last_gnt to the winner.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ram_addr = latched addr, ram_din = latched wdata, ram_en = latched we.
  - Write: go to RESP.
  - Read: load wait counter = RD_LAT, go to WAIT.
- WAIT:
  - ram_en = 0; ram_addr held.
  - Decrement counter. When it reaches 1, capture ram_dout into rdata and go to RESP.
- RESP (1 cycle):
  - Assert ack of the winner only; the other ack stays 0.
  - ram_en = 0.
  - Go to IDLE.
- Latency from req sampled in IDLE to ack: write 2 cycles, read 2 + RD_LAT cycles.
- Throughput: one transaction per (3 + RD_LAT) cycles for back-to-back reads, including the IDLE cycle.
- Requester side:
  - A requester deasserts req in the cycle after ack, or keeps it high to request again.
  - A req that stays high after ack is a new transaction.
  - A losing requester keeps req high and is guaranteed the next grant if the winner re-requests.
- rdata holds its last captured value until the next read capture; writes do not change it.
- req dropping before ack is a protocol violation: the latched transaction still completes and ack is still pulsed.
- ram_en is never high outside ISSUE; at most one RAM write per transaction.
- Reset mid-transaction aborts immediately with no ack. A write in ISSUE may or may not land in RAM.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins simultaneous requests; last_gnt is unused. B can starve while A keeps req high.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset: rst = 1 for 4 ns, then 0 → all outputs 0, busy = 0, no ack.
- Single write: A writes addr 3, data 0x5A → ram_en = 1 for exactly one cycle with ram_addr = 3 and ram_din = 0x5A; ack_a pulses 2 cycles after the req sample.
- Single read (RD_LAT = 1): B reads addr 3 → ack_b pulses 3 cycles after the req sample, with rdata = 0x5A.
- Contention: req_a and req_b held high together, 4 transactions each → grants alternate A, B, A, B…. With SRAM_ARB_FIXED_PRIO_EN defined, A is served continuously and B is not acked until req_a drops.
- Boundary: write then read at addr 0 and addr 15 (AW = 4), with RD_LAT = 3 → read ack 5 cycles after the req sample with the correct data; no address wrap.
- Reset mid-read: assert rst during WAIT → busy = 0 and no ack in that cycle; the next read after reset completes normally.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Two-requester sequencer in front of one single-port synchronous RAM; round-robin by default.
// Define SRAM_ARB_FIXED_PRIO_EN to make requester A always win simultaneous requests.
module sram_rr_arbiter #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic          last_gnt, last_gnt_d;   // 1: B was granted last
    logic          gnt_b, gnt_b_d;
    logic          tx_we, tx_we_d;
    logic [CW-1:0] cnt, cnt_d;

    logic          ack_a_d, ack_b_d, ram_en_d, busy_d;
    logic [AW-1:0] ram_addr_d;
    logic [DW-1:0] ram_din_d, rdata_d;
    logic          pick_b_c;

    // Winner selection when both requesters may be asking in IDLE
`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign pick_b_c = req_b & ~req_a;
`else
    assign pick_b_c = req_b & (~req_a | ~last_gnt);
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        last_gnt_d = last_gnt;
        gnt_b_d    = gnt_b;
        tx_we_d    = tx_we;
        cnt_d      = cnt;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        ram_en_d   = 1'b0;
        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
        rdata_d    = rdata;

        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    gnt_b_d    = pick_b_c;
                    last_gnt_d = pick_b_c;
                    tx_we_d    = pick_b_c ? we_b    : we_a;
                    ram_addr_d = pick_b_c ? addr_b  : addr_a;
                    ram_din_d  = pick_b_c ? wdata_b : wdata_a;
                    ram_en_d   = tx_we_d;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_we) begin
                    ack_a_d = ~gnt_b;
                    ack_b_d = gnt_b;
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Address stays on the bus until the read data has been captured
                if (cnt == CNT_LAST) begin
                    rdata_d = ram_dout;
                    ack_a_d = ~gnt_b;
                    ack_b_d = gnt_b;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - CNT_LAST;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_b    <= 1'b0;
            tx_we    <= 1'b0;
            cnt      <= '0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            last_gnt <= last_gnt_d;
            gnt_b    <= gnt_b_d;
            tx_we    <= tx_we_d;
            cnt      <= cnt_d;
            ack_a    <= ack_a_d;
            ack_b    <= ack_b_d;
            ram_en   <= ram_en_d;
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            rdata    <= rdata_d;
            busy     <= busy_d;
        end
    end

endmodule
